// File: rtl/garuda_dma_pkg.sv
// Shared types and constants for the Garuda 2D strided read DMA.
package garuda_dma_pkg;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam int unsigned PAGE_BYTES = 4096;
  // Descriptor fields are stored at this width; narrower address buses zero-extend.
  localparam int unsigned DESC_AW    = 32;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StData,
    StNextRow,
    StFlush,
    StErr
  } dma_state_e;

  typedef struct packed {
    logic [DESC_AW-1:0] src_addr;
    logic [DESC_AW-1:0] row_bytes;
    logic [DESC_AW-1:0] stride;
    logic [15:0]        rows;
  } dma_desc_t;

endpackage

// File: rtl/dma_engine_2d_q_if.sv
// AXI4 read address/data channel bundle between the DMA and the interconnect.
interface dma_engine_2d_q_if #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  axi_arvalid;
  logic                  axi_arready;
  logic [ADDR_WIDTH-1:0] axi_araddr;
  logic [7:0]            axi_arlen;
  logic [2:0]            axi_arsize;
  logic [1:0]            axi_arburst;
  logic                  axi_rvalid;
  logic                  axi_rready;
  logic [DATA_WIDTH-1:0] axi_rdata;
  logic [1:0]            axi_rresp;
  logic                  axi_rlast;

  modport master (
    output axi_arvalid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_rready,
    input  axi_arready, axi_rvalid, axi_rdata, axi_rresp, axi_rlast
  );

  modport slave (
    input  axi_arvalid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_rready,
    output axi_arready, axi_rvalid, axi_rdata, axi_rresp, axi_rlast
  );
endinterface

// File: rtl/dma_desc_fifo.sv
// Synchronous FIFO for queued descriptors; Depth must be a power of two.
module dma_desc_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [Width-1:0] i_wdata,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [Width-1:0] o_rdata
);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_wptr, r_rptr;
  logic [CntW-1:0]  r_count;
  logic             w_push, w_pop;

  assign o_full  = (r_count == CntW'(Depth));
  assign o_empty = (r_count == '0);
  assign w_pop   = i_pop && !o_empty;
  // A full queue still accepts a push when an entry leaves in the same cycle.
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_rdata = r_mem[r_rptr];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PtrW'(1);
      if (w_pop)  r_rptr <= r_rptr + PtrW'(1);
      r_count <= r_count + CntW'(w_push) - CntW'(w_pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end
endmodule

// File: rtl/dma_engine_2d_q.sv
// Strided 2D AXI4 read DMA: queued descriptors, 4KB-safe bursts, beats packed to a wide bus.
module dma_engine_2d_q
  import garuda_dma_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned OUT_WIDTH     = 512,
  parameter int unsigned MAX_BURST_LEN = 16,
  parameter int unsigned DESC_DEPTH    = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  desc_valid_i,
  output logic                  desc_ready_o,
  input  logic [ADDR_WIDTH-1:0] desc_src_addr_i,
  input  logic [ADDR_WIDTH-1:0] desc_row_bytes_i,
  input  logic [ADDR_WIDTH-1:0] desc_stride_i,
  input  logic [15:0]           desc_rows_i,
  output logic                  done_o,
  output logic                  error_o,
  input  logic                  err_clr_i,
  output logic                  busy_o,
  dma_engine_2d_q_if.master     axi,
  output logic                  data_valid_o,
  output logic [OUT_WIDTH-1:0]  data_o,
  output logic                  data_last_o,
  input  logic                  data_ready_i
);
  localparam int unsigned BPB     = DATA_WIDTH / 8;
  localparam int unsigned BPB_LOG = $clog2(BPB);
  localparam int unsigned WPO     = OUT_WIDTH / DATA_WIDTH;
  localparam int unsigned WIDX_W  = (WPO > 1) ? $clog2(WPO) : 1;
  localparam int unsigned AW      = ADDR_WIDTH;

  dma_state_e r_state, w_state_d;
  logic [AW-1:0] r_row_base, r_cur, r_row_left, r_row_bytes, r_stride;
  logic [15:0] r_rows_left;
  logic [OUT_WIDTH-1:0] r_pack, r_out, w_pack_next;
  logic [WIDX_W-1:0] r_widx;
  logic r_out_valid, r_out_last, r_error, r_done;

  dma_desc_t w_wdesc, w_head;
  logic w_full, w_empty, w_push, w_pop, w_legal;
  logic [AW-1:0] w_h_src, w_h_rb, w_h_stride, w_row_beats;
  logic [12:0] w_page_beats;
  logic [8:0] w_beats;
  logic w_beat, w_resp_err, w_beat_ok, w_last_beat, w_word_done;

  assign w_wdesc.src_addr  = DESC_AW'(desc_src_addr_i);
  assign w_wdesc.row_bytes = DESC_AW'(desc_row_bytes_i);
  assign w_wdesc.stride    = DESC_AW'(desc_stride_i);
  assign w_wdesc.rows      = desc_rows_i;
  assign desc_ready_o      = !w_full;
  assign w_push            = desc_valid_i && desc_ready_o;
  assign w_pop             = (r_state == StIdle) && !w_empty;

  dma_desc_fifo #(.Depth(DESC_DEPTH), .Width($bits(dma_desc_t))) u_desc_fifo (
    .i_clk   (clk_i),
    .i_rst_n (rst_ni),
    .i_push  (w_push),
    .i_wdata (w_wdesc),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_rdata (w_head)
  );

  assign w_h_src    = AW'(w_head.src_addr);
  assign w_h_rb     = AW'(w_head.row_bytes);
  assign w_h_stride = AW'(w_head.stride);
  assign w_legal    = (w_h_src[BPB_LOG-1:0] == '0) && (w_h_rb[BPB_LOG-1:0] == '0) &&
                      (w_h_stride[BPB_LOG-1:0] == '0) && (w_h_rb != '0) && (w_head.rows != '0);

  // Burst length: bounded by max burst, the rest of the row and the rest of the 4KB page.
  assign w_row_beats  = r_row_left >> BPB_LOG;
  assign w_page_beats = (13'(PAGE_BYTES) - {1'b0, r_cur[11:0]}) >> BPB_LOG;
  always_comb begin
    w_beats = 9'(MAX_BURST_LEN);
    if (w_row_beats < AW'(w_beats)) w_beats = 9'(w_row_beats);
    if (w_page_beats < 13'(w_beats)) w_beats = 9'(w_page_beats);
  end

  assign axi.axi_arvalid = (r_state == StAddr);
  assign axi.axi_araddr  = (r_state == StAddr) ? r_cur : '0;
  assign axi.axi_arlen   = (r_state == StAddr) ? 8'(w_beats - 9'd1) : 8'd0;
  assign axi.axi_arsize  = 3'(BPB_LOG);
  assign axi.axi_arburst = AXI_BURST_INCR;

  assign w_last_beat = (r_row_left == AW'(BPB)) && (r_rows_left == 16'd1);
  assign w_word_done = (r_widx == WIDX_W'(WPO - 1)) || w_last_beat;
  // Stall R only when this beat would produce a word the output register cannot take.
  assign axi.axi_rready = ((r_state == StData) &&
                           !(r_out_valid && !data_ready_i && w_word_done)) ||
                          (r_state == StErr);
  assign w_beat     = (r_state == StData) && axi.axi_rvalid && axi.axi_rready;
  assign w_resp_err = (axi.axi_rresp == AXI_RESP_SLVERR) || (axi.axi_rresp == AXI_RESP_DECERR);
  assign w_beat_ok  = w_beat && !w_resp_err;

  always_comb begin
    w_pack_next = r_pack;
    w_pack_next[int'(r_widx) * DATA_WIDTH +: DATA_WIDTH] = axi.axi_rdata;
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:    if (!w_empty) w_state_d = w_legal ? StAddr : StErr;
      StAddr:    if (axi.axi_arready) w_state_d = StData;
      StData: begin
        if (w_beat) begin
          if (w_resp_err) w_state_d = StErr;
          else if (axi.axi_rlast) begin
            if (r_row_left == AW'(BPB)) w_state_d = (r_rows_left == 16'd1) ? StFlush : StNextRow;
            else w_state_d = StAddr;
          end
        end
      end
      StNextRow: w_state_d = StAddr;
      StFlush:   if (!r_out_valid || data_ready_i) w_state_d = StIdle;
      StErr:     if (err_clr_i) w_state_d = StIdle;
      default:   w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= StIdle;
      r_error     <= 1'b0;
      r_done      <= 1'b0;
      r_row_base  <= '0;
      r_cur       <= '0;
      r_row_left  <= '0;
      r_row_bytes <= '0;
      r_stride    <= '0;
      r_rows_left <= '0;
    end else begin
      r_state <= w_state_d;
      r_error <= (w_state_d == StErr);
      r_done  <= (r_state == StFlush) && (w_state_d == StIdle);
      if (w_pop && w_legal) begin
        r_row_base  <= w_h_src;
        r_cur       <= w_h_src;
        r_row_left  <= w_h_rb;
        r_row_bytes <= w_h_rb;
        r_stride    <= w_h_stride;
        r_rows_left <= w_head.rows;
      end
      if (w_beat_ok) begin
        r_row_left <= r_row_left - AW'(BPB);
        r_cur      <= r_cur + AW'(BPB);
      end
      if (r_state == StNextRow) begin
        r_row_base  <= r_row_base + r_stride;
        r_cur       <= r_row_base + r_stride;
        r_row_left  <= r_row_bytes;
        r_rows_left <= r_rows_left - 16'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pack      <= '0;
      r_widx      <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      if ((r_state == StErr) && err_clr_i) begin
        r_pack <= '0;
        r_widx <= '0;
      end else if (w_beat_ok) begin
        r_pack <= w_word_done ? '0 : w_pack_next;
        r_widx <= w_word_done ? '0 : r_widx + WIDX_W'(1);
      end
      if (w_beat_ok && w_word_done) begin
        r_out       <= w_pack_next;
        r_out_valid <= 1'b1;
        r_out_last  <= w_last_beat;
      end else if (r_out_valid && data_ready_i) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
    end
  end

  assign data_valid_o = r_out_valid;
  assign data_o       = r_out;
  assign data_last_o  = r_out_last;
  assign done_o       = r_done;
  assign error_o      = r_error;
  assign busy_o       = (r_state != StIdle) || !w_empty;
endmodule

// File: tb/tb_dma_engine_2d_q.sv
// Scoreboard bench: directed descriptors, AXI memory slave model, decoupled AR/word monitors.
module tb_dma_engine_2d_q;
  import garuda_dma_pkg::*;

  localparam int DW = 64;
  localparam int AWD = 32;
  localparam int OW = 512;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
  } ar_t;
  typedef struct packed {
    logic [OW-1:0] data;
    logic          last;
  } word_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic desc_valid, desc_ready, done, error, err_clr, busy, dvalid, dlast, dready;
  logic [31:0] d_src, d_rb, d_stride;
  logic [15:0] d_rows;
  logic [OW-1:0] dout;

  dma_engine_2d_q_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AWD)) axi ();

  dma_engine_2d_q #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AWD), .OUT_WIDTH(OW), .MAX_BURST_LEN(16), .DESC_DEPTH(4)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .desc_valid_i     (desc_valid),
    .desc_ready_o     (desc_ready),
    .desc_src_addr_i  (d_src),
    .desc_row_bytes_i (d_rb),
    .desc_stride_i    (d_stride),
    .desc_rows_i      (d_rows),
    .done_o           (done),
    .error_o          (error),
    .err_clr_i        (err_clr),
    .busy_o           (busy),
    .axi              (axi),
    .data_valid_o     (dvalid),
    .data_o           (dout),
    .data_last_o      (dlast),
    .data_ready_i     (dready)
  );

  ar_t   exp_ar[$];
  ar_t   ar_q[$];
  word_t exp_w[$];
  int n_checks = 0;
  int n_fails = 0;
  int done_cnt = 0;
  int r_busy = 0;
  logic [31:0] err_addr = 32'hFFFF_FFFF;

  task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mem_word(input logic [31:0] a);
    return {a ^ 32'h5A5A_0000, ~a};
  endfunction

  task automatic exp_ar_push(input logic [31:0] a, input logic [7:0] l);
    ar_t e;
    e.addr = a;
    e.len  = l;
    exp_ar.push_back(e);
  endtask

  // Expected packed words for a descriptor, walked address by address.
  task automatic expect_desc(input logic [31:0] src, input logic [31:0] rb,
                             input logic [31:0] stride, input int rows);
    word_t w;
    int idx = 0;
    logic lst;
    w.data = '0;
    for (int r = 0; r < rows; r++) begin
      for (int b = 0; b < int'(rb / 8); b++) begin
        w.data[idx*64 +: 64] = mem_word(src + 32'(r) * stride + 32'(b * 8));
        idx++;
        lst = (r == rows - 1) && (b == int'(rb / 8) - 1);
        if (idx == 8 || lst) begin
          w.last = lst;
          exp_w.push_back(w);
          w.data = '0;
          idx = 0;
        end
      end
    end
  endtask

  // AR slave and monitor: toggling arready, address-hold check, expected AR compare.
  initial begin
    logic pend;
    logic [31:0] pa;
    logic [7:0] pl;
    ar_t e, t;
    pend = 1'b0;
    axi.axi_arready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) pend = 1'b0;
      else begin
        if (pend) begin
          check("ar_hold_addr", axi.axi_araddr, pa);
          check("ar_hold_len", axi.axi_arlen, pl);
        end
        pend = 1'b0;
        if (axi.axi_arvalid && axi.axi_arready) begin
          t.addr = axi.axi_araddr;
          t.len  = axi.axi_arlen;
          ar_q.push_back(t);
          if (exp_ar.size() == 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL ar_unexpected: got addr %0h len %0d expected none", t.addr, t.len);
          end else begin
            e = exp_ar.pop_front();
            check("ar_addr", t.addr, e.addr);
            check("ar_len", t.len, e.len);
          end
        end else if (axi.axi_arvalid) begin
          pend = 1'b1;
          pa = axi.axi_araddr;
          pl = axi.axi_arlen;
        end
      end
      @(posedge clk);
      #1;
      axi.axi_arready = ~axi.axi_arready;
    end
  end

  // R channel memory model: serves accepted bursts in order, SLVERR at err_addr.
  initial begin
    ar_t b;
    logic [31:0] a;
    logic f;
    axi.axi_rvalid = 1'b0;
    axi.axi_rdata = '0;
    axi.axi_rresp = AXI_RESP_OKAY;
    axi.axi_rlast = 1'b0;
    forever begin
      if (ar_q.size() == 0) begin
        @(posedge clk);
        #1;
      end else begin
        b = ar_q.pop_front();
        r_busy = 1;
        for (int k = 0; k <= int'(b.len); k++) begin
          a = b.addr + 32'(k * 8);
          axi.axi_rvalid = 1'b1;
          axi.axi_rdata  = mem_word(a);
          axi.axi_rresp  = (a == err_addr) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
          axi.axi_rlast  = (k == int'(b.len));
          do begin
            @(negedge clk);
            f = axi.axi_rvalid && axi.axi_rready;
            @(posedge clk);
            #1;
          end while (!f);
        end
        axi.axi_rvalid = 1'b0;
        axi.axi_rlast  = 1'b0;
        axi.axi_rresp  = AXI_RESP_OKAY;
        r_busy = 0;
      end
    end
  end

  // Output word monitor with hold-under-stall check.
  initial begin
    logic stall;
    logic [OW-1:0] sd;
    word_t e;
    stall = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) stall = 1'b0;
      else begin
        if (stall) begin
          check("stall_valid", dvalid, 1);
          check("stall_data", dout, sd);
        end
        stall = 1'b0;
        if (dvalid && dready) begin
          if (exp_w.size() == 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL word_unexpected: got %0h expected none", dout);
          end else begin
            e = exp_w.pop_front();
            check("word_data", dout, e.data);
            check("word_last", dlast, e.last);
          end
        end else if (dvalid) begin
          stall = 1'b1;
          sd = dout;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && done) done_cnt++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_desc(input logic [31:0] src, input logic [31:0] rb,
                           input logic [31:0] stride, input logic [15:0] rows);
    int t = 0;
    logic f;
    desc_valid = 1'b1;
    d_src = src;
    d_rb = rb;
    d_stride = stride;
    d_rows = rows;
    do begin
      @(negedge clk);
      f = desc_valid && desc_ready;
      @(posedge clk);
      #1;
      t++;
    end while (!f && t < 500);
    desc_valid = 1'b0;
    if (!f) begin
      n_checks++;
      n_fails++;
      $display("FAIL push_timeout: got desc_ready 0 expected 1");
    end
  endtask

  task automatic wait_done(input int target);
    int t = 0;
    while (done_cnt < target && t < 3000) begin
      cyc(1);
      t++;
    end
    cyc(3);
    check("done_count", done_cnt, target);
    check("words_pending", exp_w.size(), 0);
    check("ar_pending", exp_ar.size(), 0);
  endtask

  task automatic wait_error();
    int t = 0;
    while (!error && t < 500) begin
      cyc(1);
      t++;
    end
    check("err_set", error, 1);
  endtask

  task automatic clear_error();
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
    check("err_cleared", error, 0);
  endtask

  task automatic check_reset_outputs();
    check("rst_arvalid", axi.axi_arvalid, 0);
    check("rst_araddr", axi.axi_araddr, 0);
    check("rst_arlen", axi.axi_arlen, 0);
    check("rst_arsize", axi.axi_arsize, 3);
    check("rst_arburst", axi.axi_arburst, 1);
    check("rst_rready", axi.axi_rready, 0);
    check("rst_dvalid", dvalid, 0);
    check("rst_data", dout, 0);
    check("rst_dlast", dlast, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_busy", busy, 0);
    check("rst_desc_ready", desc_ready, 1);
  endtask

  initial begin
    int t;
    rst_n = 1'b0;
    desc_valid = 1'b0;
    d_src = '0;
    d_rb = '0;
    d_stride = '0;
    d_rows = '0;
    err_clr = 1'b0;
    dready = 1'b1;
    #12;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(2);

    // 1D row: one 16-beat burst, two full words.
    exp_ar_push(32'h1000, 8'd15);
    expect_desc(32'h1000, 32'd128, 32'd0, 1);
    push_desc(32'h1000, 32'd128, 32'd0, 16'd1);
    wait_done(1);
    check("idle_busy", busy, 0);

    // 2D strided: three rows of 4 beats, last word half-filled.
    exp_ar_push(32'h2000, 8'd3);
    exp_ar_push(32'h2100, 8'd3);
    exp_ar_push(32'h2200, 8'd3);
    expect_desc(32'h2000, 32'd32, 32'd256, 3);
    push_desc(32'h2000, 32'd32, 32'd256, 16'd3);
    wait_done(2);

    // 4KB split.
    exp_ar_push(32'h0FF0, 8'd1);
    exp_ar_push(32'h1000, 8'd5);
    expect_desc(32'h0FF0, 32'd64, 32'd0, 1);
    push_desc(32'h0FF0, 32'd64, 32'd0, 16'd1);
    wait_done(3);

    // Consumer stall for 20 cycles once the first word is presented.
    dready = 1'b0;
    exp_ar_push(32'h3000, 8'd15);
    exp_ar_push(32'h3080, 8'd15);
    expect_desc(32'h3000, 32'd256, 32'd0, 1);
    push_desc(32'h3000, 32'd256, 32'd0, 16'd1);
    t = 0;
    while (!dvalid && t < 200) begin
      cyc(1);
      t++;
    end
    check("bp_first_valid", dvalid, 1);
    cyc(20);
    check("bp_rready_low", axi.axi_rready, 0);
    dready = 1'b1;
    wait_done(4);

    // SLVERR on beat 2; queued descriptor completes after clear.
    err_addr = 32'h4010;
    exp_ar_push(32'h4000, 8'd15);
    exp_ar_push(32'h5000, 8'd7);
    expect_desc(32'h5000, 32'd64, 32'd0, 1);
    push_desc(32'h4000, 32'd128, 32'd0, 16'd1);
    push_desc(32'h5000, 32'd64, 32'd0, 16'd1);
    wait_error();
    t = 0;
    while ((r_busy != 0 || ar_q.size() != 0) && t < 200) begin
      cyc(1);
      t++;
    end
    cyc(4);
    check("err_drained_rready", axi.axi_rready, 1);
    check("err_sticky", error, 1);
    check("err_no_done", done_cnt, 4);
    check("err_no_ar", exp_ar.size(), 1);
    check("err_busy", busy, 1);
    err_addr = 32'hFFFF_FFFF;
    clear_error();
    wait_done(5);

    // Illegal descriptor parks the engine in ERR; fill the queue behind it.
    push_desc(32'h6004, 32'd16, 32'd0, 16'd1);
    wait_error();
    for (int i = 0; i < 4; i++) begin
      exp_ar_push(32'h7000 + 32'(i * 256), 8'(i));
      expect_desc(32'h7000 + 32'(i * 256), 32'(8 * (i + 1)), 32'd0, 1);
      push_desc(32'h7000 + 32'(i * 256), 32'(8 * (i + 1)), 32'd0, 16'd1);
    end
    check("q_full_ready", desc_ready, 0);
    exp_ar_push(32'h7400, 8'd4);
    expect_desc(32'h7400, 32'd40, 32'd0, 1);
    clear_error();
    push_desc(32'h7400, 32'd40, 32'd0, 16'd1);
    wait_done(10);

    // Asynchronous reset in the middle of a burst.
    exp_ar_push(32'h8000, 8'd15);
    expect_desc(32'h8000, 32'd128, 32'd0, 1);
    push_desc(32'h8000, 32'd128, 32'd0, 16'd1);
    cyc(6);
    check("mid_rready", axi.axi_rready, 1);
    #3;
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
